// File: rtl/alu_seq.sv
// Handshaked sequential ALU: FWD/ADD/AND/OR/SUB in one cycle, shift-add MUL and bitwise SLL/SRA iterate.
// Latency: 1 edge for simple ops, WIDTH for MUL, max(1, min(shamt, WIDTH)) for shifts.
// Backpressure: START is taken only while idle; BUSY stalls the requester. Optional flags via ALU_FLAGS_EN.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       select_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
`ifdef ALU_FLAGS_EN
    ,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             negative_o
`endif
);

    localparam int SHAMT_W = $clog2(WIDTH) + 1;
    localparam logic [SHAMT_W-1:0] WIDTH_C = SHAMT_W'(WIDTH);

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;      // operand A; shifted left by MUL, shifted by SLL/SRA
    logic [WIDTH-1:0]   b_q, b_d;      // operand B; shifted right by MUL to expose the next multiplier bit
    logic [WIDTH-1:0]   acc_q, acc_d;  // MUL partial product
    logic [SHAMT_W-1:0] cnt_q, cnt_d;  // remaining iterations, completion when it reaches 1
    logic               sh_en_q, sh_en_d; // shift ops with shamt 0 pass A through untouched
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;
`ifdef ALU_FLAGS_EN
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;
    logic               negative_q, negative_d;
`endif

    // Datapath helpers shared by the FSM below
    logic               is_sub, is_addsub;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH-1:0]   mul_nxt;
    logic [WIDTH-1:0]   shift_nxt;
    logic [SHAMT_W-1:0] shamt, steps;
    logic [WIDTH-1:0]   res_v;

    assign is_sub    = (op_q == OP_SUB);
    assign is_addsub = (op_q == OP_ADD) || is_sub;
    assign b_eff     = is_sub ? ~b_q : b_q;
    assign sum_w     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign mul_nxt   = acc_q + (b_q[0] ? a_q : '0);
    assign shift_nxt = (op_q == OP_SLL) ? {a_q[WIDTH-2:0], 1'b0} : {a_q[WIDTH-1], a_q[WIDTH-1:1]};
    assign shamt     = data2_i[SHAMT_W-1:0];
    assign steps     = (shamt > WIDTH_C) ? WIDTH_C : shamt;

    // Value written to RESULT on the completing edge
    always_comb begin
        res_v = b_q;
        case (op_q)
            OP_FWD:         res_v = b_q;
            OP_ADD, OP_SUB: res_v = sum_w[WIDTH-1:0];
            OP_AND:         res_v = a_q & b_q;
            OP_OR:          res_v = a_q | b_q;
            OP_MUL:         res_v = mul_nxt;
            default:        res_v = sh_en_q ? shift_nxt : a_q;
        endcase
    end

    // Next-state and datapath update: accept in IDLE, iterate in RUN, complete when count hits 1
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sh_en_d  = sh_en_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
`ifdef ALU_FLAGS_EN
        carry_d    = carry_q;
        overflow_d = overflow_q;
        negative_d = negative_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    op_d    = select_i;
                    a_d     = data1_i;
                    b_d     = data2_i;
                    acc_d   = '0;
                    sh_en_d = (shamt != '0);
                    if (select_i == OP_MUL)
                        cnt_d = WIDTH_C;
                    else if ((select_i == OP_SLL || select_i == OP_SRA) && steps != '0)
                        cnt_d = steps;
                    else
                        cnt_d = SHAMT_W'(1);
                end
            end
            RUN: begin
                if (op_q == OP_MUL) begin
                    acc_d = mul_nxt;
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                    b_d   = {1'b0, b_q[WIDTH-1:1]};
                end else if ((op_q == OP_SLL || op_q == OP_SRA) && sh_en_q) begin
                    a_d = shift_nxt;
                end
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d  = IDLE;
                    result_d = res_v;
                    zero_d   = (res_v == '0);
                    done_d   = 1'b1;
`ifdef ALU_FLAGS_EN
                    carry_d    = is_addsub ? sum_w[WIDTH] : 1'b0;
                    overflow_d = is_addsub && (a_q[WIDTH-1] == b_eff[WIDTH-1])
                                 && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
                    negative_d = res_v[WIDTH-1];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; reset aborts any op in flight
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            op_q     <= OP_FWD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sh_en_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef ALU_FLAGS_EN
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sh_en_q  <= sh_en_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
`ifdef ALU_FLAGS_EN
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            negative_q <= negative_d;
`endif
        end
    end

    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign busy_o   = (state_q == RUN);
    assign done_o   = done_q;
`ifdef ALU_FLAGS_EN
    assign carry_o    = carry_q;
    assign overflow_o = overflow_q;
    assign negative_o = negative_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed vector table, multi-cycle corner sequences,
// and random ops scored against an arithmetic reference model.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [2:0] select_i;
    logic [7:0] data1_i, data2_i;
    logic [7:0] result_o;
    logic       zero_o, busy_o, done_o;
`ifdef ALU_FLAGS_EN
    logic       carry_o, overflow_o, negative_o;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .select_i(select_i),
        .data1_i(data1_i), .data2_i(data2_i), .result_o(result_o), .zero_o(zero_o),
        .busy_o(busy_o), .done_o(done_o)
`ifdef ALU_FLAGS_EN
        , .carry_o(carry_o), .overflow_o(overflow_o), .negative_o(negative_o)
`endif
    );

    typedef struct {
        logic [2:0] sel;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] res;
        logic       z;
        int         lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Reference: results from plain arithmetic on the operands
    function automatic logic [7:0] ref_res(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        int sh;
        sh = int'(b[3:0]);
        p  = 16'(a) * 16'(b);
        case (s)
            3'd0: return b;
            3'd1: return a + b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a - b;
            3'd5: return p[7:0];
            3'd6: return (sh >= 8) ? 8'h00 : (a << sh);
            default: return (sh >= 8) ? {8{a[7]}} : 8'($signed(a) >>> sh);
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] s, input logic [7:0] b);
        int sh;
        sh = int'(b[3:0]);
        if (s == 3'd5) return 8;
        if (s == 3'd6 || s == 3'd7) return (sh == 0) ? 1 : ((sh > 8) ? 8 : sh);
        return 1;
    endfunction

    // Issue one op, scramble operands after acceptance, wait (bounded) for DONE
    task automatic run_op(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic z, output int lat,
                          output logic busy0, output logic busy_end);
        select_i = s; data1_i = a; data2_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        busy0 = busy_o;
        data1_i = 8'($urandom); data2_i = 8'($urandom); select_i = 3'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done_o && lat < 40);
        r = result_o; z = zero_o; busy_end = busy_o;
    endtask

    vec_t vecs[14];

    initial begin
        logic [7:0] r, rr;
        logic       z, b0, be;
        int         lat;
        logic [2:0] s;
        logic [7:0] a, b;
        bit         saw_done;

        vecs[0]  = '{3'd1, 8'h05, 8'h03, 8'h08, 1'b0, 1};
        vecs[1]  = '{3'd4, 8'h2A, 8'h2A, 8'h00, 1'b1, 1};
        vecs[2]  = '{3'd0, 8'h55, 8'hC3, 8'hC3, 1'b0, 1};
        vecs[3]  = '{3'd5, 8'd13, 8'd11, 8'h8F, 1'b0, 8};
        vecs[4]  = '{3'd7, 8'h90, 8'h03, 8'hF2, 1'b0, 3};
        vecs[5]  = '{3'd6, 8'h01, 8'h09, 8'h00, 1'b1, 8};
        vecs[6]  = '{3'd6, 8'hA5, 8'h00, 8'hA5, 1'b0, 1};
        vecs[7]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1};
        vecs[8]  = '{3'd3, 8'h00, 8'h00, 8'h00, 1'b1, 1};
        vecs[9]  = '{3'd7, 8'h7F, 8'h0F, 8'h00, 1'b1, 8};
        vecs[10] = '{3'd4, 8'h00, 8'h01, 8'hFF, 1'b0, 1};
        vecs[11] = '{3'd6, 8'h81, 8'h08, 8'h00, 1'b1, 8};
        vecs[12] = '{3'd5, 8'hFF, 8'hFF, 8'h01, 1'b0, 8};
        vecs[13] = '{3'd7, 8'h80, 8'h07, 8'hFF, 1'b0, 7};

        reset_i = 1'b1; start_i = 1'b0; select_i = 3'd0; data1_i = 8'h00; data2_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", 32'(result_o), 32'h0);
        chk("reset_zero",   32'(zero_o),   32'h1);
        chk("reset_busy",   32'(busy_o),   32'h0);
        chk("reset_done",   32'(done_o),   32'h0);
        reset_i = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].d1, vecs[i].d2, r, z, lat, b0, be);
            chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
            chk($sformatf("vec%0d_zero", i),   32'(z), 32'(vecs[i].z));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_busy_start", i), 32'(b0), 32'h1);
            chk($sformatf("vec%0d_busy_at_done", i), 32'(be), 32'h0);
        end

`ifdef ALU_FLAGS_EN
        run_op(3'd1, 8'h7F, 8'h01, r, z, lat, b0, be);
        chk("flags_ovf_result", 32'(r), 32'h80);
        chk("flags_ovf_overflow", 32'(overflow_o), 32'h1);
        chk("flags_ovf_carry", 32'(carry_o), 32'h0);
        chk("flags_ovf_negative", 32'(negative_o), 32'h1);
        run_op(3'd1, 8'hFF, 8'h01, r, z, lat, b0, be);
        chk("flags_carry_carry", 32'(carry_o), 32'h1);
        chk("flags_carry_zero", 32'(z), 32'h1);
        chk("flags_carry_overflow", 32'(overflow_o), 32'h0);
        run_op(3'd4, 8'h05, 8'h03, r, z, lat, b0, be);
        chk("flags_sub_carry", 32'(carry_o), 32'h1);
        run_op(3'd5, 8'h10, 8'h10, r, z, lat, b0, be);
        chk("flags_mul_carry", 32'(carry_o), 32'h0);
`endif

        // MUL with a stray START at cycle 3: must be ignored
        select_i = 3'd5; data1_i = 8'd13; data2_i = 8'd11; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) begin select_i = 3'd1; data1_i = 8'h01; data2_i = 8'h01; start_i = 1'b1; end
            else start_i = 1'b0;
        end while (!done_o && lat < 40);
        chk("mul_ignore_start_latency", 32'(lat), 32'd8);
        chk("mul_ignore_start_result", 32'(result_o), 32'h8F);
        @(posedge clk); #1;
        chk("mul_ignore_start_no_second_op", 32'(busy_o), 32'h0);

        // START held across the DONE edge: ignored there, accepted the cycle after
        select_i = 3'd1; data1_i = 8'h01; data2_i = 8'h01; start_i = 1'b1;
        @(posedge clk); #1;
        chk("held_start_busy1", 32'(busy_o), 32'h1);
        @(posedge clk); #1;
        chk("held_start_done1", 32'(done_o), 32'h1);
        chk("held_start_not_busy_at_done", 32'(busy_o), 32'h0);
        data1_i = 8'h10; data2_i = 8'h20;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("held_start_reaccepted", 32'(busy_o), 32'h1);
        chk("held_start_no_done", 32'(done_o), 32'h0);
        @(posedge clk); #1;
        chk("held_start_done2", 32'(done_o), 32'h1);
        chk("held_start_result2", 32'(result_o), 32'h30);

        // Reset in the middle of a MUL aborts it without DONE
        select_i = 3'd5; data1_i = 8'd7; data2_i = 8'd9; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'h0);
        chk("abort_result", 32'(result_o), 32'h0);
        chk("abort_zero", 32'(zero_o), 32'h1);
        chk("abort_done", 32'(done_o), 32'h0);
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done_o) saw_done = 1'b1;
        end
        chk("abort_no_late_done", 32'(saw_done), 32'h0);
        run_op(3'd1, 8'h05, 8'h03, r, z, lat, b0, be);
        chk("after_abort_add_result", 32'(r), 32'h08);
        chk("after_abort_add_latency", 32'(lat), 32'd1);

        // Random ops against the reference model
        for (int k = 0; k < 80; k++) begin
            s = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = 8'($urandom);
            if (k % 4 == 0) b = {4'($urandom), 4'($urandom_range(0, 9))};
            run_op(s, a, b, r, z, lat, b0, be);
            rr = ref_res(s, a, b);
            chk($sformatf("rand%0d_op%0d_%0h_%0h_result", k, s, a, b), 32'(r), 32'(rr));
            chk($sformatf("rand%0d_zero", k), 32'(z), 32'(rr == 8'h00));
            chk($sformatf("rand%0d_latency", k), 32'(lat), 32'(ref_lat(s, b)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
